mult_datapath_resp: RTL and testbench
=====================================

// Module: mult_datapath_resp
// PURPOSE
//   Responder end of the start/ld/clr control interface. Accepts ld/clr commands from the
//   control FSM and runs an unsigned shift-add multiply over WIDTH cycles.
//   Reports completion with busy and a one-cycle done pulse. Holds product until the next
//   command. Sits beside the control FSM; the control FSM drives ld/clr, this block answers.
// PARAMETERS
//   WIDTH   8   operand width in bits; product is 2*WIDTH bits; legal range 2..32
// PORTS
//   clk       in   1         single clock; all state updates on posedge clk
//   reset_n   in   1         synchronous, active-low reset
//   clr       in   1         synchronous clear command from control FSM
//   ld        in   1         load-and-start command from control FSM
//   a         in   WIDTH     multiplicand; sampled only on an accepted ld
//   b         in   WIDTH     multiplier; sampled only on an accepted ld
//   busy      out  1         high while a multiply is in progress (state RUN)
//   done      out  1         one-cycle pulse; product valid from this cycle on
//   product   out  2*WIDTH   result register
// BEHAVIOUR
//   - Reset (reset_n=0 at posedge): state=IDLE, busy=0, done=0, product=0, count=0, operand regs=0.
//     Reset wins over every other input and aborts any operation.
//   - Command priority at each edge: reset_n=0 > clr > ld.
//   - clr=1: same register effect as reset (product=0, busy=0, done=0, state=IDLE),
//     in any state, including mid-RUN.
//   - States:
//     - IDLE:
//       - ld=1 -> latch a, b; acc=0; count=0; go to RUN.
//       - else stay in IDLE.
//     - RUN:
//       - busy=1. Each edge: if the multiplier LSB is 1, acc += multiplicand (shifted).
//         Shift the multiplier right and the multiplicand left. count++.
//       - When count reaches WIDTH-1 on an edge, the final partial product is added,
//         product<=acc, and the state goes to DONE.
//       - ld in RUN is ignored. No re-latch, no restart.
//     - DONE:
//       - done=1 and busy=0 for exactly one cycle; next edge -> IDLE.
//       - ld=1 in DONE is accepted exactly as in IDLE (back-to-back operations).
//   - Latency: ld accepted at edge E0 -> busy high after E0 through E_WIDTH.
//     done is high in the cycle after edge E_WIDTH. Total = WIDTH+1 cycles from ld to done.
//   - product keeps its last value in IDLE/DONE; it changes only at RUN->DONE, on clr, or on reset.
//   - Arithmetic: unsigned, no overflow. The accumulator is 2*WIDTH bits and the
//     multiplicand shift register is 2*WIDTH bits.
//   - Counter width: $clog2(WIDTH). No wrap is reachable, because count resets on each ld.
//   - ld and clr together: clr wins; ld is dropped (not queued).
//   - Outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//   - Shared package mult_pkg:
//     - state encoding localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2;
//     - default WIDTH.
//   - One sub-module, shift_add_step: a combinational single-step
//     (acc, mcand, mplier) -> (acc', mcand', mplier').
//     The top level holds the FSM, the counter and all registers.
//   - The encoding value 2'd3 is unused and must recover to IDLE on the next edge.
// TESTING
//   1. WIDTH=8. reset_n=0 for 2 cycles, then 1.
//      -> product=0, busy=0, done=0 with no ld applied.
//   2. a=13, b=11, ld pulsed 1 cycle.
//      -> busy for 8 cycles; done pulse in cycle 9; product=143, held until the next command.
//   3. a=255, b=255 -> product=65025. Then a=0, b=200 -> product=0, with done still pulsing once.
//   4. a=6, b=7, ld; at cycle 3 of RUN, ld again with a=1, b=1.
//      -> second ld ignored; product=42.
//   5. a=9, b=9, ld; clr at cycle 4 of RUN.
//      -> next cycle: busy=0, product=0, no done pulse.
//      ld+clr together -> stays IDLE.
//   6. a=5, b=5, ld; reset_n=0 at cycle 2 of RUN -> all outputs 0.
//      Then ld in the DONE cycle of a 3*4 run gives product=12, followed by a back-to-back result.

Source files
------------

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared encoding and defaults for the shift-add multiplier
package mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Encoding 2'd3 is deliberately unused; the FSM steers it back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_datapath_resp_shift_add_step.sv
// rtl/mult_datapath_resp_shift_add_step.sv - one combinational shift-add multiply step
module shift_add_step #(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [2*WIDTH-1:0] mcand_next,
  output logic [WIDTH-1:0]   mplier_next
);

  assign acc_next    = acc + (mplier[0] ? mcand : '0);
  assign mcand_next  = {mcand[2*WIDTH-2:0], 1'b0};
  assign mplier_next = {1'b0, mplier[WIDTH-1:1]};

endmodule

// File: rtl/mult_datapath_resp.sv
// rtl/mult_datapath_resp.sv - ld/clr responder running an unsigned WIDTH-cycle shift-add multiply
module mult_datapath_resp
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               ld,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t               state_q;
  state_t               state_d;
  logic [CW-1:0]        count;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   mcand_next;
  logic [WIDTH-1:0]     mplier_next;
  logic                 last_step;

  shift_add_step #(.WIDTH(WIDTH)) u_step (
    .acc         (acc),
    .mcand       (mcand),
    .mplier      (mplier),
    .acc_next    (acc_next),
    .mcand_next  (mcand_next),
    .mplier_next (mplier_next)
  );

  assign last_step = (count == LAST);

  // clr and reset are applied in the register process, so they override this.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = ld ? RUN : IDLE;
      RUN:     state_d = last_step ? DONE : RUN;
      DONE:    state_d = ld ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      state_q <= IDLE;
      count   <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE, DONE: begin
          if (ld) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            count  <= '0;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand_next;
          mplier <= mplier_next;
          count  <= count + CW'(1);
          if (last_step) begin
            product <= acc_next;
          end
        end
        default: begin
          count <= '0;
        end
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_mult_datapath_resp.sv
// tb/tb_mult_datapath_resp.sv - self-checking bench for mult_datapath_resp
module tb_mult_datapath_resp;

  localparam int W = 8;

  logic           clk;
  logic           reset_n;
  logic           clr;
  logic           ld;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int total = 0;
  int bad   = 0;

  mult_datapath_resp #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .ld      (ld),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a countdown of busy cycles and a pending product a*b.
  int           run_left = 0;
  bit           m_done   = 1'b0;
  logic [2*W-1:0] m_prod = '0;
  logic [2*W-1:0] m_pend = '0;

  always @(posedge clk) begin
    if (!reset_n || clr) begin
      run_left = 0;
      m_done   = 1'b0;
      m_prod   = '0;
    end else if (run_left > 0) begin
      run_left = run_left - 1;
      if (run_left == 0) begin
        m_done = 1'b1;
        m_prod = m_pend;
      end
    end else begin
      m_done = 1'b0;
      if (ld) begin
        m_pend   = {8'd0, a} * {8'd0, b};
        run_left = W;
      end
    end
    #1;
    total++;
    if (busy !== (run_left > 0) || done !== m_done || product !== m_prod) begin
      bad++;
      $display("FAIL model t=%0t busy=%b/%b done=%b/%b product=%0d/%0d",
               $time, busy, (run_left > 0), done, m_done, product, m_prod);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Issues ld in the current cycle, then waits (bounded) for the done pulse.
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y,
                    output int nbusy, output bit got);
    a = x; b = y; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    nbusy = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done) got = 1'b1;
      else begin
        if (busy) nbusy++;
        @(negedge clk);
      end
    end
  endtask

  int nb;
  bit got;
  bit saw_done;

  initial begin
    reset_n = 1'b0; clr = 1'b0; ld = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_product", 32'(product), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);

    op(8'd13, 8'd11, nb, got);
    chk("t2_done_seen", 32'(got), 1);
    chk("t2_busy_cycles", 32'(nb), 8);
    chk("t2_product", 32'(product), 143);
    repeat (3) @(negedge clk);
    chk("t2_hold_product", 32'(product), 143);
    chk("t2_single_done", 32'(done), 0);

    op(8'd255, 8'd255, nb, got);
    chk("t3_max_product", 32'(product), 65025);
    @(negedge clk);
    op(8'd0, 8'd200, nb, got);
    chk("t3_zero_done", 32'(got), 1);
    chk("t3_zero_product", 32'(product), 0);
    @(negedge clk);

    a = 8'd6; b = 8'd7; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'd1; b = 8'd1; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 20 && !saw_done; i++) begin
      if (done) saw_done = 1'b1;
      else @(negedge clk);
    end
    chk("t4_done_seen", 32'(saw_done), 1);
    chk("t4_ignored_ld", 32'(product), 42);
    @(negedge clk);

    a = 8'd9; b = 8'd9; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t5_clr_busy", 32'(busy), 0);
    chk("t5_clr_product", 32'(product), 0);
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    chk("t5_no_done", 32'(saw_done), 0);
    a = 8'd3; b = 8'd3; ld = 1'b1; clr = 1'b1;
    @(negedge clk);
    ld = 1'b0; clr = 1'b0;
    chk("t5_ldclr_busy", 32'(busy), 0);
    @(negedge clk);
    chk("t5_ldclr_idle", 32'(busy), 0);

    a = 8'd5; b = 8'd5; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_product", 32'(product), 0);
    op(8'd3, 8'd4, nb, got);
    chk("t6_first_product", 32'(product), 12);
    op(8'd2, 8'd7, nb, got);
    chk("t6_b2b_busy_cycles", 32'(nb), 8);
    chk("t6_b2b_product", 32'(product), 14);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
